word_uart_tx: RTL and testbench

WORD_UART_TX -- requirements
Module: word_uart_tx

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_byte_tx.sv | 88 ++++++++
 rtl/word_uart_tx.sv | 70 +++++++
 tb/tb_word_uart_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared FSM encoding and framing constants for the word UART transmitter
// and its byte serializer.
package uart_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int BITS_PER_BYTE  = 8;
  localparam int BYTES_PER_WORD = 2;
endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serializer. A start request seen in IDLE, or in the last
// stop-bit cycle, loads a new byte with no idle gap between frames.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        start,
  input  logic [7:0]  data,
  output logic        tx,
  output logic        last,
  output uart_state_e state
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(BITS_PER_BYTE);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_BYTE - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [BW-1:0] bit_q;
  logic [7:0]    sh_q;
  logic          tx_q, tx_d;
  logic          load, shift, bit_end;

  assign bit_end = (cnt_q == CNT_MAX);
  assign last    = (state_q == ST_STOP) && bit_end;
  assign tx      = tx_q;
  assign state   = state_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_START;
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA:  if (bit_end && (bit_q == BIT_LAST)) state_d = ST_STOP;
      ST_STOP:  if (bit_end) state_d = start ? ST_START : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // tx_d is the line level for the next bit period; registering it keeps tx glitch-free.
  always_comb begin
    tx_d  = tx_q;
    load  = 1'b0;
    shift = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        tx_d = 1'b0;
        load = 1'b1;
      end
      ST_START: if (bit_end) tx_d = sh_q[0];
      ST_DATA: if (bit_end) begin
        shift = 1'b1;
        tx_d  = (bit_q == BIT_LAST) ? 1'b1 : sh_q[1];
      end
      ST_STOP: if (bit_end && start) begin
        tx_d = 1'b0;
        load = 1'b1;
      end
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
      tx_q  <= 1'b1;
    end else begin
      tx_q <= tx_d;
      if (load)       sh_q <= data;
      else if (shift) sh_q <= sh_q >> 1;
      if ((state_q == ST_IDLE) || bit_end) cnt_q <= '0;
      else                                 cnt_q <= cnt_q + 1'b1;
      if (state_q != ST_DATA) bit_q <= '0;
      else if (bit_end)       bit_q <= bit_q + 1'b1;
    end
  end
endmodule

// File: rtl/word_uart_tx.sv
// 16-bit word transmitter: sends the low byte then the high byte as two
// back-to-back 8N1 frames through one byte serializer.
module word_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [15:0] data_in,
  input  logic        data_in_valid,
  output logic        tx,
  output logic        tx_done,
  output logic        busy,
  output logic        overrun,
  output uart_state_e dbg_state
);
  // Handshake: a word transfers on a rising edge with data_in_valid=1 and
  // busy=0 (busy is the inverse of ready); valid while busy drops the word
  // and latches overrun.
  logic        byte_sel_q, busy_q, done_q, ovr_q;
  logic [15:0] word_q;
  logic        accept, last, start, last_byte, word_end;
  logic [7:0]  byte_data;
  uart_state_e byte_state;

  assign accept    = data_in_valid && (byte_state == ST_IDLE);
  assign last_byte = (byte_sel_q == 1'(BYTES_PER_WORD - 1));
  assign start     = accept || (last && !last_byte);
  assign word_end  = last && last_byte;
  assign byte_data = accept ? data_in[7:0] : word_q[15:8];

  assign busy      = busy_q;
  assign tx_done   = done_q;
  assign overrun   = ovr_q;
  assign dbg_state = byte_state;

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk   (clk),
    .rstb  (rstb),
    .start (start),
    .data  (byte_data),
    .tx    (tx),
    .last  (last),
    .state (byte_state)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      word_q     <= '0;
      byte_sel_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      done_q <= word_end;
      ovr_q  <= ovr_q | (data_in_valid & busy_q);
      if (accept) begin
        word_q     <= data_in;
        byte_sel_q <= 1'b0;
        busy_q     <= 1'b1;
      end else if (last) begin
        byte_sel_q <= ~byte_sel_q;
        if (last_byte) busy_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_word_uart_tx.sv
// Bench for word_uart_tx: per-cycle expected {tx,busy,tx_done} values are
// queued from a frame model and compared on falling edges.
module tb_word_uart_tx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rstb;
  logic [15:0] data_in, data_in2;
  logic        data_in_valid, data_in_valid2;
  logic        tx, tx_done, busy, overrun;
  logic        tx2, tx_done2, busy2, overrun2;
  uart_state_e dbg_state, dbg_state2;

  logic [2:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  word_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rstb(rstb), .data_in(data_in), .data_in_valid(data_in_valid),
    .tx(tx), .tx_done(tx_done), .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
  );

  word_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rstb(rstb), .data_in(data_in2), .data_in_valid(data_in_valid2),
    .tx(tx2), .tx_done(tx_done2), .busy(busy2), .overrun(overrun2), .dbg_state(dbg_state2)
  );

  // One entry per clock: {tx, busy, tx_done}; word ends with its tx_done cycle.
  task automatic push_word(input logic [15:0] w, input int cpb);
    logic [9:0] frame;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      frame = {1'b1, w[8*b +: 8], 1'b0};
      for (int k = 0; k < 10; k++)
        for (int c = 0; c < cpb; c++) exp_q.push_back({frame[k], 1'b1, 1'b0});
    end
    exp_q.push_back(3'b101);
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(3'b100);
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    data_in = 16'hFFFF; data_in_valid = 1'b1;
    data_in2 = 16'h0000; data_in_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, busy, tx_done, overrun} !== 4'b1000) begin
      $display("FAIL reset_outputs: {tx,busy,tx_done,overrun}=%b expected 1000", {tx, busy, tx_done, overrun});
    end else passes++;
    checks++;
    if (dbg_state !== ST_IDLE) $display("FAIL reset_state: state=%0d expected %0d", dbg_state, ST_IDLE);
    else passes++;
    checks++;
    if ({tx2, busy2, tx_done2, overrun2} !== 4'b1000) begin
      $display("FAIL reset_outputs2: {tx,busy,tx_done,overrun}=%b expected 1000", {tx2, busy2, tx_done2, overrun2});
    end else passes++;
    rstb = 1'b1; data_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx, busy} !== 2'b10) $display("FAIL post_reset_idle: {tx,busy}=%b expected 10", {tx, busy});
    else passes++;
  endtask

  task automatic test_basic();
    logic [2:0] e;
    int i = 0;
    @(negedge clk);
    data_in = 16'hA55A; data_in_valid = 1'b1;
    push_word(16'hA55A, 4); push_idle(3);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      data_in_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({tx, busy, tx_done} !== e) $display("FAIL basic cyc %0d: {tx,busy,tx_done}=%b expected %b", i, {tx, busy, tx_done}, e);
      else passes++;
      i++;
    end
    checks++;
    if (overrun !== 1'b0) $display("FAIL basic_overrun: overrun=%b expected 0", overrun);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    int i = 0;
    @(negedge clk);
    data_in = 16'hA55A; data_in_valid = 1'b1;
    push_word(16'hA55A, 4); push_word(16'h1234, 4); push_idle(3);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({tx, busy, tx_done} !== e) $display("FAIL b2b cyc %0d: {tx,busy,tx_done}=%b expected %b", i, {tx, busy, tx_done}, e);
      else passes++;
      // Second word offered in the tx_done cycle of the first.
      data_in_valid = (i == 80);
      if (i == 80) data_in = 16'h1234;
      i++;
    end
    checks++;
    if (overrun !== 1'b0) $display("FAIL b2b_overrun: overrun=%b expected 0", overrun);
    else passes++;
  endtask

  task automatic test_overrun();
    logic [2:0] e;
    int i = 0;
    @(negedge clk);
    data_in = 16'h0000; data_in_valid = 1'b1;
    push_word(16'h0000, 4); push_idle(3);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({tx, busy, tx_done} !== e) $display("FAIL overrun cyc %0d: {tx,busy,tx_done}=%b expected %b", i, {tx, busy, tx_done}, e);
      else passes++;
      data_in_valid = (i == 9);
      if (i == 9) data_in = 16'hFFFF;
      i++;
    end
    checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_flag: overrun=%b expected 1", overrun);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    int i = 0;
    @(negedge clk);
    data_in = 16'h3C5A; data_in_valid = 1'b1;
    push_word(16'h3C5A, 4);
    for (int k = 0; k < 37; k++) begin
      @(negedge clk);
      data_in_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({tx, busy, tx_done} !== e) $display("FAIL abort_pre cyc %0d: {tx,busy,tx_done}=%b expected %b", k, {tx, busy, tx_done}, e);
      else passes++;
    end
    exp_q.delete();
    #1 rstb = 1'b0;
    #1;
    checks++;
    if ({tx, busy, tx_done, overrun} !== 4'b1000) begin
      $display("FAIL abort_async: {tx,busy,tx_done,overrun}=%b expected 1000", {tx, busy, tx_done, overrun});
    end else passes++;
    // Valid held during reset must not be taken until rstb is high.
    data_in = 16'h00FF; data_in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx, busy, tx_done} !== 3'b100) $display("FAIL abort_hold: {tx,busy,tx_done}=%b expected 100", {tx, busy, tx_done});
    else passes++;
    rstb = 1'b1;
    push_word(16'h00FF, 4); push_idle(3);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      data_in_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({tx, busy, tx_done} !== e) $display("FAIL abort_next cyc %0d: {tx,busy,tx_done}=%b expected %b", i, {tx, busy, tx_done}, e);
      else passes++;
      i++;
    end
    checks++;
    if (overrun !== 1'b0) $display("FAIL abort_overrun: overrun=%b expected 0", overrun);
    else passes++;
  endtask

  task automatic test_held_valid();
    logic [2:0] e;
    int i = 0;
    @(negedge clk);
    data_in = 16'h8001; data_in_valid = 1'b1;
    push_word(16'h8001, 4); push_word(16'h8001, 4); push_idle(3);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({tx, busy, tx_done} !== e) $display("FAIL held cyc %0d: {tx,busy,tx_done}=%b expected %b", i, {tx, busy, tx_done}, e);
      else passes++;
      // High for 160 edges: covers the acceptances at edges 0 and 81 only.
      data_in_valid = (i < 159);
      i++;
    end
    checks++;
    if (overrun !== 1'b1) $display("FAIL held_overrun: overrun=%b expected 1", overrun);
    else passes++;
  endtask

  task automatic test_cpb2();
    logic [2:0] e;
    int i = 0;
    @(negedge clk);
    data_in2 = 16'h0001; data_in_valid2 = 1'b1;
    push_word(16'h0001, 2); push_idle(3);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      data_in_valid2 = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({tx2, busy2, tx_done2} !== e) $display("FAIL cpb2 cyc %0d: {tx,busy,tx_done}=%b expected %b", i, {tx2, busy2, tx_done2}, e);
      else passes++;
      i++;
    end
    checks++;
    if (overrun2 !== 1'b0) $display("FAIL cpb2_overrun: overrun=%b expected 0", overrun2);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_held_valid();
    test_cpb2();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
